gemm_seq_ctrl: RTL and testbench
================================

// Module: gemm_seq_ctrl
// PURPOSE
//  Sequencer + accumulator for dense GEMM Co = alpha*(A x B) + beta*C over M x N x K tiles.
//  Walks i,j,k indices, issues reads to A/B/C memories (1-cycle read latency), accumulates the
//  true sum over k, scales and writes each Co[i][j] through a valid/ready port.
//  Replaces the single-cycle loop-nest datapath; one element in flight at a time.
// PARAMETERS
//  DATA_W   32   element/coefficient width; all arithmetic modulo 2^DATA_W
//  IDX_W    7    index width; max dimension 2^IDX_W-1 (127, covers 100x100)
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       1-cycle request; sampled only in IDLE
//  dim_m      in   IDX_W   rows of A/Co (latched on accepted start)
//  dim_n      in   IDX_W   cols of B/Co (latched)
//  dim_k      in   IDX_W   inner dimension (latched)
//  alpha      in   DATA_W  product scale (latched)
//  beta       in   DATA_W  C scale (latched)
//  busy       out  1       high from accepted start until done
//  done       out  1       1-cycle pulse after last write handshake
//  rd_en      out  1       read strobe to A, B, C memories
//  rd_i/rd_j/rd_k out IDX_W  A addr=(rd_i,rd_k), B addr=(rd_k,rd_j), C addr=(rd_i,rd_j)
//  rd_c       out  1       C read qualifier (first k beat of each element)
//  a_data/b_data/c_data in DATA_W  read data, valid the cycle after rd_en
//  wr_valid   out  1       Co write request; held with wr_i/wr_j/wr_data until wr_ready
//  wr_ready   in   1       sink accepts when wr_valid && wr_ready
//  wr_i/wr_j  out  IDX_W   Co write address;  wr_data out DATA_W  result
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, rd_en, rd_c, wr_valid = 0; indices, acc, wr_data = 0.
//  FSM: IDLE -start-> (any dim==0 ? FINISH : MAC). MAC: rd_en=1, rd_k=0..K-1, one beat/cycle;
//   rd_c=1 on k==0. Last beat -> DRAIN (accumulate final returned beat) -> SCALE -> WRITE.
//   WRITE: wr_valid=1 until wr_ready; on handshake j++ (wrap to 0, i++); if i==M-1 && j==N-1
//   -> FINISH else MAC. FINISH: done=1 one cycle, busy=0 next cycle, -> IDLE.
//  Accumulate: acc cleared on first returned beat, acc += a_data*b_data (low DATA_W bits).
//  Scale: wr_data = alpha*acc + beta*c_reg, each product and sum truncated to DATA_W.
//  Order: row-major (i outer, j inner); elements written exactly once, in order.
//  Latency per element = K+3 cycles with wr_ready=1; total = M*N*(K+3)+1 from start to done.
//  start while busy: ignored. Dims latched; input changes mid-run have no effect.
//  dim_k==0 or dim_m==0 or dim_n==0: no reads, no writes, done pulses the cycle after start.
//  wr_ready low: WRITE stalls, wr_* stable, no new reads issued.
//  rst_n asserted mid-run: immediate return to reset values; partial results abandoned.
// CONFIGURATION
//  GEMM_PERF_CNT_EN defined: adds outputs perf_cycles[31:0] (cycles with busy=1) and
//   perf_stalls[31:0] (cycles in WRITE with wr_ready=0); both cleared on accepted start,
//   saturate at all-ones, hold after done. Undefined: ports and counters absent, no other change.
// STRUCTURE
//  gemm_pkg: DATA_W/IDX_W defaults, gemm_state_e {IDLE,MAC,DRAIN,SCALE,WRITE,FINISH}.
//  Sub-module gemm_mac_unit: accumulator + alpha/beta scale stage (clr, acc_en, scale_en);
//   gemm_seq_ctrl holds FSM, index counters, handshake.
// TESTING
//  M=N=K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], C=all 1, alpha=1, beta=2 -> writes 21,24,45,52
//   in order (0,0),(0,1),(1,0),(1,1); done at cycle 21 after start.
//  M=N=K=100, A=B=identity, C=all 3, alpha=5, beta=1 -> Co diag=8, off-diag=3; 10000 writes.
//  dim_k=0 with start -> no rd_en, no wr_valid; done high 1 cycle after start.
//  wr_ready low 4 cycles on first write -> wr_valid/wr_data/addr stable; no rd_en; total +4.
//  A=B=32'h8000_0000, K=2, alpha=beta=1, C=0 -> wr_data=0 (modulo wrap); start pulsed while
//   busy -> ignored; rst_n low mid-MAC -> all outputs 0 next edge, restart runs clean.
//  GEMM_PERF_CNT_EN: first case with 2 stall cycles -> perf_cycles=23, perf_stalls=2.

Source files
------------

// File: rtl/gemm_pkg.sv
// Shared widths and FSM state encoding for the GEMM sequencer and its MAC unit.
// Optional perf counters in gemm_seq_ctrl are enabled with GEMM_PERF_CNT_EN.
package gemm_pkg;

    localparam int GEMM_DATA_W = 32;
    localparam int GEMM_IDX_W  = 7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MAC    = 3'd1,
        DRAIN  = 3'd2,
        SCALE  = 3'd3,
        WRITE  = 3'd4,
        FINISH = 3'd5
    } gemm_state_e;

endpackage

// File: rtl/gemm_mac_unit.sv
// Accumulator over returned A*B beats plus alpha/beta scale stage; all math modulo 2^DATA_W.
// Latency: one cycle per accumulate beat, one cycle for scale; result held until next scale_en.
module gemm_mac_unit
    import gemm_pkg::*;
#(
    parameter int DATA_W = GEMM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              acc_en,
    input  logic              scale_en,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    input  logic [DATA_W-1:0] c_data,
    input  logic [DATA_W-1:0] alpha,
    input  logic [DATA_W-1:0] beta,
    output logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_c;
    logic [DATA_W-1:0] r_res;
    logic [DATA_W-1:0] w_prod;
    logic [DATA_W-1:0] w_scaled;

    assign w_prod   = a_data * b_data;
    assign w_scaled = (alpha * r_acc) + (beta * r_c);

    // The first beat of an element both restarts the sum and carries the C operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_c   <= '0;
            r_res <= '0;
        end else begin
            if (acc_en) begin
                if (clr) begin
                    r_acc <= w_prod;
                    r_c   <= c_data;
                end else begin
                    r_acc <= r_acc + w_prod;
                end
            end
            if (scale_en) begin
                r_res <= w_scaled;
            end
        end
    end

    assign wr_data = r_res;

endmodule

// File: rtl/gemm_seq_ctrl.sv
// GEMM sequencer: walks i,j,k, reads A/B/C, writes Co = alpha*(A x B) + beta*C; GEMM_PERF_CNT_EN adds perf counters.
// Latency K+3 cycles per element; wr_ready low stalls WRITE with wr_* held and no reads issued.
module gemm_seq_ctrl
    import gemm_pkg::*;
#(
    parameter int DATA_W = GEMM_DATA_W,
    parameter int IDX_W  = GEMM_IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IDX_W-1:0]  dim_m,
    input  logic [IDX_W-1:0]  dim_n,
    input  logic [IDX_W-1:0]  dim_k,
    input  logic [DATA_W-1:0] alpha,
    input  logic [DATA_W-1:0] beta,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [IDX_W-1:0]  rd_i,
    output logic [IDX_W-1:0]  rd_j,
    output logic [IDX_W-1:0]  rd_k,
    output logic              rd_c,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    input  logic [DATA_W-1:0] c_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [IDX_W-1:0]  wr_i,
    output logic [IDX_W-1:0]  wr_j,
    output logic [DATA_W-1:0] wr_data
`ifdef GEMM_PERF_CNT_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stalls
`endif
);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_MAC    = MAC;
    localparam logic [2:0] S_DRAIN  = DRAIN;
    localparam logic [2:0] S_SCALE  = SCALE;
    localparam logic [2:0] S_WRITE  = WRITE;
    localparam logic [2:0] S_FINISH = FINISH;

    logic [2:0]        r_state;
    logic [IDX_W-1:0]  r_i;
    logic [IDX_W-1:0]  r_j;
    logic [IDX_W-1:0]  r_k;
    logic [IDX_W-1:0]  r_dim_m;
    logic [IDX_W-1:0]  r_dim_n;
    logic [IDX_W-1:0]  r_dim_k;
    logic [DATA_W-1:0] r_alpha;
    logic [DATA_W-1:0] r_beta;
    logic              r_beat_vld;
    logic              r_beat_first;

    logic              w_in_mac;
    logic              w_k_last;
    logic              w_i_last;
    logic              w_j_last;
    logic              w_zero_dim;
    logic              w_start_acc;
    logic              w_wr_hs;

    assign w_in_mac    = (r_state == S_MAC);
    assign w_k_last    = (r_k == (r_dim_k - IDX_W'(1)));
    assign w_i_last    = (r_i == (r_dim_m - IDX_W'(1)));
    assign w_j_last    = (r_j == (r_dim_n - IDX_W'(1)));
    assign w_zero_dim  = (dim_m == '0) || (dim_n == '0) || (dim_k == '0);
    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_wr_hs     = (r_state == S_WRITE) && wr_ready;

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_FINISH);
    assign wr_valid = (r_state == S_WRITE);
    assign rd_en    = w_in_mac;
    assign rd_c     = w_in_mac && (r_k == '0);
    assign rd_i     = r_i;
    assign rd_j     = r_j;
    assign rd_k     = r_k;
    assign wr_i     = r_i;
    assign wr_j     = r_j;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_i          <= '0;
            r_j          <= '0;
            r_k          <= '0;
            r_dim_m      <= '0;
            r_dim_n      <= '0;
            r_dim_k      <= '0;
            r_alpha      <= '0;
            r_beta       <= '0;
            r_beat_vld   <= 1'b0;
            r_beat_first <= 1'b0;
        end else begin
            // Read data returns one cycle after the strobe; track which beat it is.
            r_beat_vld   <= rd_en;
            r_beat_first <= rd_c;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dim_m <= dim_m;
                        r_dim_n <= dim_n;
                        r_dim_k <= dim_k;
                        r_alpha <= alpha;
                        r_beta  <= beta;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_k     <= '0;
                        r_state <= w_zero_dim ? S_FINISH : S_MAC;
                    end
                end
                S_MAC: begin
                    if (w_k_last) begin
                        r_k     <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_k <= r_k + IDX_W'(1);
                    end
                end
                S_DRAIN: r_state <= S_SCALE;
                S_SCALE: r_state <= S_WRITE;
                S_WRITE: begin
                    if (wr_ready) begin
                        if (w_i_last && w_j_last) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_state <= S_MAC;
                            if (w_j_last) begin
                                r_j <= '0;
                                r_i <= r_i + IDX_W'(1);
                            end else begin
                                r_j <= r_j + IDX_W'(1);
                            end
                        end
                    end
                end
                S_FINISH: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    gemm_mac_unit #(
        .DATA_W (DATA_W)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (r_beat_first),
        .acc_en   (r_beat_vld),
        .scale_en (r_state == S_SCALE),
        .a_data   (a_data),
        .b_data   (b_data),
        .c_data   (c_data),
        .alpha    (r_alpha),
        .beta     (r_beta),
        .wr_data  (wr_data)
    );

`ifdef GEMM_PERF_CNT_EN
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_stalls;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_cycles <= '0;
            r_perf_stalls <= '0;
        end else if (w_start_acc) begin
            r_perf_cycles <= '0;
            r_perf_stalls <= '0;
        end else begin
            if (busy && (r_perf_cycles != '1)) begin
                r_perf_cycles <= r_perf_cycles + 32'd1;
            end
            if (wr_valid && !w_wr_hs && (r_perf_stalls != '1)) begin
                r_perf_stalls <= r_perf_stalls + 32'd1;
            end
        end
    end

    assign perf_cycles = r_perf_cycles;
    assign perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_gemm_seq_ctrl.sv
// Directed bench for gemm_seq_ctrl: memory model, write scoreboard, cycle-accurate done checks.
module tb_gemm_seq_ctrl;

    localparam int DW = 32;
    localparam int IW = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [IW-1:0] dim_m, dim_n, dim_k;
    logic [DW-1:0] alpha, beta;
    logic          busy, done, rd_en, rd_c, wr_valid, wr_ready;
    logic [IW-1:0] rd_i, rd_j, rd_k, wr_i, wr_j;
    logic [DW-1:0] a_data = '0, b_data = '0, c_data = '0;
    logic [DW-1:0] wr_data;
`ifdef GEMM_PERF_CNT_EN
    logic [31:0]   perf_cycles, perf_stalls;
`endif

    always #5 clk = ~clk;

    gemm_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dim_m(dim_m), .dim_n(dim_n), .dim_k(dim_k),
        .alpha(alpha), .beta(beta),
        .busy(busy), .done(done), .rd_en(rd_en),
        .rd_i(rd_i), .rd_j(rd_j), .rd_k(rd_k), .rd_c(rd_c),
        .a_data(a_data), .b_data(b_data), .c_data(c_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_i(wr_i), .wr_j(wr_j), .wr_data(wr_data)
`ifdef GEMM_PERF_CNT_EN
        , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [IW-1:0] i;
        logic [IW-1:0] j;
        logic [DW-1:0] d;
    } exp_t;
    exp_t sb_q[$];

    logic [DW-1:0] mem_a [128][128];
    logic [DW-1:0] mem_b [128][128];
    logic [DW-1:0] mem_c [128][128];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int i, input int j, input logic [DW-1:0] d);
        exp_t e;
        e.i = IW'(i);
        e.j = IW'(j);
        e.d = d;
        sb_q.push_back(e);
    endtask

    // Memory model: 1-cycle read latency.
    logic          pend_en = 1'b0;
    logic [IW-1:0] pend_i, pend_j, pend_k;
    always @(negedge clk) begin
        pend_en = rd_en;
        pend_i  = rd_i;
        pend_j  = rd_j;
        pend_k  = rd_k;
    end
    always @(posedge clk) begin
        #1;
        if (pend_en) begin
            a_data = mem_a[pend_i][pend_k];
            b_data = mem_b[pend_k][pend_j];
            c_data = mem_c[pend_i][pend_j];
        end
    end

    // Write monitor: pops the scoreboard on each handshake, checks stability while stalled.
    logic          held = 1'b0;
    logic [IW-1:0] h_i, h_j;
    logic [DW-1:0] h_d;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held = 1'b0;
        end else if (wr_valid) begin
            if (held) begin
                check("stall_hold", 64'({wr_i, wr_j, wr_data}), 64'({h_i, h_j, h_d}));
                check("stall_no_rd", 64'(rd_en), 64'(0));
            end
            if (wr_ready) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got (%0d,%0d)=0x%0h, expected no write",
                             wr_i, wr_j, wr_data);
                end else begin
                    e = sb_q.pop_front();
                    check("wr_addr", 64'({wr_i, wr_j}), 64'({e.i, e.j}));
                    check("wr_data", 64'(wr_data), 64'(e.d));
                end
                held = 1'b0;
            end else begin
                held = 1'b1;
                h_i  = wr_i;
                h_j  = wr_j;
                h_d  = wr_data;
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic check_zero(input string name);
        check({name, "_ctl"}, 64'({busy, done, rd_en, rd_c, wr_valid}), 64'(0));
        check({name, "_idx"}, 64'({rd_i, rd_j, rd_k, wr_i, wr_j}), 64'(0));
        check({name, "_wr_data"}, 64'(wr_data), 64'(0));
    endtask

    // Start in cycle 0; done expected in cycle exp_done.
    task automatic run(input string name, input int m, input int n, input int k,
                       input logic [DW-1:0] al, input logic [DW-1:0] be,
                       input int exp_done, input int n_stall, input int pulse_cyc,
                       input bit reads);
        int cyc      = 0;
        int done_cyc = -1;
        int stalled  = 0;
        bit saw_rd   = 0;
        bit saw_wr   = 0;
        bit rel_rdy  = 0;
        @(posedge clk); #1;
        start    = 1'b1;
        dim_m    = IW'(m);
        dim_n    = IW'(n);
        dim_k    = IW'(k);
        alpha    = al;
        beta     = be;
        wr_ready = (n_stall == 0);
        while (done_cyc < 0 && cyc <= exp_done + 40) begin
            @(negedge clk);
            if (rd_en) saw_rd = 1;
            if (wr_valid) saw_wr = 1;
            if (wr_valid && !wr_ready) begin
                stalled++;
                if (stalled >= n_stall) rel_rdy = 1;
            end
            if (done) begin
                done_cyc = cyc;
                check({name, "_busy_at_done"}, 64'(busy), 64'(1));
            end
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (cyc == pulse_cyc) begin
                start = 1'b1;
                dim_m = 7'd3;
                dim_n = 7'd3;
                dim_k = 7'd3;
                alpha = 32'h0000_0007;
                beta  = 32'h0000_0009;
            end
            if (cyc == pulse_cyc + 1) start = 1'b0;
            if (rel_rdy) wr_ready = 1'b1;
        end
        check({name, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
        check({name, "_stall_cycles"}, 64'(stalled), 64'(n_stall));
        @(negedge clk);
        check({name, "_after_done"}, 64'({busy, done}), 64'(0));
        check({name, "_sb_drained"}, 64'(sb_q.size()), 64'(0));
        if (!reads) begin
            check({name, "_no_reads"}, 64'(saw_rd), 64'(0));
            check({name, "_no_writes"}, 64'(saw_wr), 64'(0));
        end
`ifdef GEMM_PERF_CNT_EN
        check({name, "_perf_cycles"}, 64'(perf_cycles), 64'(exp_done));
        check({name, "_perf_stalls"}, 64'(perf_stalls), 64'(n_stall));
`endif
    endtask

    task automatic load_2x2();
        mem_a[0][0] = 1; mem_a[0][1] = 2; mem_a[1][0] = 3; mem_a[1][1] = 4;
        mem_b[0][0] = 5; mem_b[0][1] = 6; mem_b[1][0] = 7; mem_b[1][1] = 8;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                mem_c[i][j] = 1;
    endtask

    task automatic push_2x2();
        push(0, 0, 21); push(0, 1, 24); push(1, 0, 45); push(1, 1, 52);
    endtask

    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dim_m    = '0;
        dim_n    = '0;
        dim_k    = '0;
        alpha    = '0;
        beta     = '0;
        wr_ready = 1'b1;
        for (int i = 0; i < 128; i++)
            for (int j = 0; j < 128; j++) begin
                mem_a[i][j] = '0;
                mem_b[i][j] = '0;
                mem_c[i][j] = '0;
            end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        load_2x2();
        push_2x2();
        run("gemm2x2", 2, 2, 2, 1, 2, 21, 0, -1, 1);

        push_2x2();
        run("stall4", 2, 2, 2, 1, 2, 25, 4, -1, 1);

`ifdef GEMM_PERF_CNT_EN
        push_2x2();
        run("stall2", 2, 2, 2, 1, 2, 23, 2, -1, 1);
`endif

        run("dimk0", 2, 2, 0, 1, 2, 1, 0, -1, 0);
        run("dimm0", 0, 3, 3, 1, 2, 1, 0, -1, 0);

        // K=1: Co[0][j] = 3*2*(j+1) + 10
        mem_a[0][0] = 2;
        for (int j = 0; j < 3; j++) begin
            mem_b[0][j] = DW'(j + 1);
            mem_c[0][j] = 10;
        end
        push(0, 0, 16); push(0, 1, 22); push(0, 2, 28);
        run("k1row", 1, 3, 1, 3, 1, 13, 0, -1, 1);

        // 2^31 * 2^31 wraps to 0; a start pulse mid-run must be ignored.
        mem_a[0][0] = 32'h8000_0000; mem_a[0][1] = 32'h8000_0000;
        mem_b[0][0] = 32'h8000_0000; mem_b[1][0] = 32'h8000_0000;
        mem_c[0][0] = 0;
        push(0, 0, 0);
        run("wrap", 1, 1, 2, 1, 1, 6, 0, 2, 1);

        // Reset in the middle of MAC, then a clean rerun.
        @(posedge clk); #1;
        start = 1'b1; dim_m = 2; dim_n = 2; dim_k = 2; alpha = 1; beta = 2;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("pre_reset_active", 64'({busy, rd_en}), 64'(3));
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("midrun_reset");
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        load_2x2();
        push_2x2();
        run("rerun", 2, 2, 2, 1, 2, 21, 0, -1, 1);

        // Identity A, B with K=100: diag 5*1+3 = 8, off-diag 3.
        for (int i = 0; i < 128; i++)
            for (int j = 0; j < 128; j++) begin
                mem_a[i][j] = (i == j) ? 1 : 0;
                mem_b[i][j] = (i == j) ? 1 : 0;
                mem_c[i][j] = 3;
            end
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 10; j++)
                push(i, j, (i == j) ? 8 : 3);
        run("identity", 10, 10, 100, 5, 1, 10301, 0, -1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
